// File: rtl/fp_div_result_stage.sv
// Registered result stage behind the single-precision combinational divider.
// Applies IEEE-754 special-case fix-up, queues results in a small FIFO with
// valid/ready on both sides, and tracks per-result and sticky exception flags
// plus a saturating count of results handed downstream.
module fp_div_result_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      in_result,
  input  logic             in_overflag,
  input  logic             in_underflag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       sticky_flags,
  input  logic             clear_sticky,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  // Flag bit positions within {invalid, divzero, overflow, underflow}
  localparam int unsigned FlagInvalid = 3;
  localparam int unsigned FlagDivZero = 2;
  localparam int unsigned FlagOvf     = 1;
  localparam int unsigned FlagUnf     = 0;

  // ---------------------------------------------------------------------------
  // Operand classification
  // ---------------------------------------------------------------------------
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_nan, a_inf, a_zero;
  logic        b_nan, b_inf, b_zero;
  logic        res_sign;

  assign a_exp  = in_a[30:23];
  assign a_frac = in_a[22:0];
  assign b_exp  = in_b[30:23];
  assign b_frac = in_b[22:0];

  // Denormals (exp == 0, frac != 0) are treated as zero without raising a flag
  assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign a_zero = (a_exp == 8'h00);
  assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign b_zero = (b_exp == 8'h00);

  assign res_sign = in_a[31] ^ in_b[31];

  // ---------------------------------------------------------------------------
  // Special-case fix-up; first matching rule wins
  // ---------------------------------------------------------------------------
  logic [31:0] fix_result;
  logic [3:0]  fix_flags;

  // Select the fixed-up result and exception flags for the current operands
  always_comb begin
    fix_result = in_result;
    fix_flags  = 4'b0000;
    if (a_nan || b_nan) begin
      fix_result             = QNaN;
      fix_flags[FlagInvalid] = 1'b1;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      fix_result             = QNaN;
      fix_flags[FlagInvalid] = 1'b1;
    end else if (a_inf) begin
      fix_result = {res_sign, 8'hFF, 23'd0};
    end else if (b_zero) begin
      fix_result             = {res_sign, 8'hFF, 23'd0};
      fix_flags[FlagDivZero] = 1'b1;
    end else if (b_inf || a_zero) begin
      fix_result = {res_sign, 31'd0};
    end else if (in_overflag) begin
      fix_result         = {res_sign, 8'hFF, 23'd0};
      fix_flags[FlagOvf] = 1'b1;
    end else if (in_underflag) begin
      fix_result         = {res_sign, 31'd0};
      fix_flags[FlagUnf] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]     mem_result_q [DEPTH];
  logic [3:0]      mem_flags_q  [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            live_q;
  logic            push, pop;

  // live_q holds in_ready low during reset and for the cycle up to the first edge
  assign in_ready  = live_q && (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = out_valid ? mem_result_q[rd_ptr_q] : 32'd0;
  assign out_flags  = out_valid ? mem_flags_q[rd_ptr_q]  : 4'd0;

  // Pointer and occupancy next-state; pointers wrap naturally as DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= 1'b1;
    end
  end

  // FIFO storage; cleared on reset so no stale entry can ever be observed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_result_q[i] <= 32'd0;
        mem_flags_q[i]  <= 4'd0;
      end
    end else if (push) begin
      mem_result_q[wr_ptr_q] <= fix_result;
      mem_flags_q[wr_ptr_q]  <= fix_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags and operation counter
  // ---------------------------------------------------------------------------
  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Clear applies to the old value only, so a same-cycle push survives it
  always_comb begin
    sticky_d   = (clear_sticky ? 4'd0 : sticky_q) | (push ? fix_flags : 4'd0);
    op_count_d = op_count_q;
    if (pop && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  // Sticky flag and counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q   <= 4'd0;
      op_count_q <= '0;
    end else begin
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
    end
  end

  assign sticky_flags = sticky_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_fp_div_result_stage.sv
// Directed self-checking bench for fp_div_result_stage (DEPTH=2, CNT_W=16).
module tb_fp_div_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_result;
  logic        in_overflag;
  logic        in_underflag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [3:0]  sticky_flags;
  logic        clear_sticky;
  logic [15:0] op_count;

  int checks;
  int errors;

  fp_div_result_stage #(
    .DEPTH(2),
    .CNT_W(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_result   (in_result),
    .in_overflag (in_overflag),
    .in_underflag(in_underflag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .sticky_flags(sticky_flags),
    .clear_sticky(clear_sticky),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set operand inputs (no handshake)
  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic of, input logic uf);
    in_a         = a;
    in_b         = b;
    in_result    = r;
    in_overflag  = of;
    in_underflag = uf;
  endtask

  // Offer one operation for exactly one edge, sample 1 time unit later
  task automatic push_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                          input logic of, input logic uf);
    set_op(a, b, r, of, uf);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_sticky = 1'b1;
    @(posedge clk);
    #1;
    clear_sticky = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
    set_op(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_result !== 32'd0) begin errors++;
      $display("FAIL reset_out_result got %h want 0", out_result); end
    checks++; if (out_flags !== 4'd0) begin errors++;
      $display("FAIL reset_out_flags got %b want 0", out_flags); end
    checks++; if (sticky_flags !== 4'd0) begin errors++;
      $display("FAIL reset_sticky got %b want 0", sticky_flags); end
    checks++; if (op_count !== 16'd0) begin errors++;
      $display("FAIL reset_op_count got %0d want 0", op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_release_in_ready got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_first_edge_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_normal();
    push_one(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL normal_valid got %b want 1", out_valid); end
    checks++; if (out_result !== 32'h4040_0000) begin errors++;
      $display("FAIL normal_result got %h want 40400000", out_result); end
    checks++; if (out_flags !== 4'b0000) begin errors++;
      $display("FAIL normal_flags got %b want 0000", out_flags); end
    pop_one();
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd0) begin errors++;
      $display("FAIL normal_drain got valid=%b result=%h want 0/0", out_valid, out_result); end
    checks++; if (op_count !== 16'd1) begin errors++;
      $display("FAIL normal_op_count got %0d want 1", op_count); end
  endtask

  task automatic test_specials();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vr [4];
    logic [3:0]  vf [4];
    va[0] = 32'h3F80_0000; vb[0] = 32'h0000_0000; vr[0] = 32'h7F80_0000; vf[0] = 4'b0100;
    va[1] = 32'h0000_0000; vb[1] = 32'h0000_0000; vr[1] = 32'h7FC0_0000; vf[1] = 4'b1000;
    va[2] = 32'hFF80_0000; vb[2] = 32'h3F80_0000; vr[2] = 32'hFF80_0000; vf[2] = 4'b0000;
    va[3] = 32'h7FC0_0001; vb[3] = 32'h3F80_0000; vr[3] = 32'h7FC0_0000; vf[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      push_one(va[i], vb[i], 32'h1234_5678, 1'b0, 1'b0);
      checks++; if (out_result !== vr[i]) begin errors++;
        $display("FAIL special%0d_result got %h want %h", i, out_result, vr[i]); end
      checks++; if (out_flags !== vf[i]) begin errors++;
        $display("FAIL special%0d_flags got %b want %b", i, out_flags, vf[i]); end
      checks++; if (sticky_flags !== vf[i]) begin errors++;
        $display("FAIL special%0d_sticky got %b want %b", i, sticky_flags, vf[i]); end
      pop_one();
      pulse_clear();
      checks++; if (sticky_flags !== 4'b0000) begin errors++;
        $display("FAIL special%0d_clear got %b want 0000", i, sticky_flags); end
    end
  endtask

  task automatic test_saturation();
    push_one(32'hC200_0000, 32'h3F80_0000, 32'h1111_1111, 1'b1, 1'b0);
    checks++; if (out_result !== 32'hFF80_0000 || out_flags !== 4'b0010) begin errors++;
      $display("FAIL overflow got %h/%b want ff800000/0010", out_result, out_flags); end
    pop_one();
    push_one(32'hC200_0000, 32'h3F80_0000, 32'h1111_1111, 1'b0, 1'b1);
    checks++; if (out_result !== 32'h8000_0000 || out_flags !== 4'b0001) begin errors++;
      $display("FAIL underflow got %h/%b want 80000000/0001", out_result, out_flags); end
    checks++; if (sticky_flags !== 4'b0011) begin errors++;
      $display("FAIL sat_sticky got %b want 0011", sticky_flags); end
    pop_one();
    pulse_clear();
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    push_one(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
    push_one(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
    set_op(32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0 || out_result !== 32'h3F80_0000) begin errors++;
      $display("FAIL bp_held got ready=%b head=%h want 0/3f800000", in_ready, out_result); end
    out_ready = 1'b1;
    #1;
    checks++; if (out_result !== 32'h3F80_0000) begin errors++;
      $display("FAIL bp_order1 got %h want 3f800000", out_result); end
    @(posedge clk);
    #1;
    // Pop while full must not admit the held third item
    checks++; if (out_result !== 32'h4000_0000 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_order2 got head=%h ready=%b want 40000000/1", out_result, in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (out_result !== 32'h4040_0000 || out_valid !== 1'b1) begin errors++;
      $display("FAIL bp_order3 got head=%h valid=%b want 40400000/1", out_result, out_valid); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL bp_empty got %b want 0", out_valid); end
    checks++; if (op_count !== 16'd3) begin errors++;
      $display("FAIL bp_op_count got %0d want 3", op_count); end
  endtask

  task automatic test_sticky_collision();
    push_one(32'h3F80_0000, 32'h3F80_0000, 32'h0, 1'b1, 1'b0);
    checks++; if (sticky_flags !== 4'b0010) begin errors++;
      $display("FAIL coll_pre got %b want 0010", sticky_flags); end
    clear_sticky = 1'b1;
    out_ready    = 1'b1;
    push_one(32'h3F80_0000, 32'h0000_0000, 32'h0, 1'b0, 1'b0);
    clear_sticky = 1'b0;
    checks++; if (sticky_flags !== 4'b0100) begin errors++;
      $display("FAIL coll_sticky got %b want 0100", sticky_flags); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || op_count !== 16'd5) begin errors++;
      $display("FAIL coll_drain got valid=%b cnt=%0d want 0/5", out_valid, op_count); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    push_one(32'h3F80_0000, 32'h0000_0000, 32'h0, 1'b0, 1'b0);
    push_one(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || sticky_flags !== 4'b0100) begin errors++;
      $display("FAIL mid_pre got valid=%b sticky=%b want 1/0100", out_valid, sticky_flags); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd0) begin errors++;
      $display("FAIL mid_out got valid=%b result=%h want 0/0", out_valid, out_result); end
    checks++; if (sticky_flags !== 4'd0 || op_count !== 16'd0) begin errors++;
      $display("FAIL mid_state got sticky=%b cnt=%0d want 0/0", sticky_flags, op_count); end
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL mid_in_ready_low got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL mid_release got ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal();
    test_specials();
    test_saturation();
    test_backpressure();
    test_sticky_collision();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_result_stage.md
# fp_div_result_stage

Registered result stage that sits directly downstream of the single-precision combinational divider. It takes the operands A and B, the raw divider result, and the divider's `overflag`/`underflag`, and applies IEEE-754 special-case fix-up: NaN, zero, infinity, divide-by-zero, and overflow/underflow saturation. It buffers fixed-up results in a small FIFO with valid/ready handshakes on both sides, and keeps per-result and sticky exception flags plus a completed-operation counter.

## Interface
- `DEPTH`, 2 — output FIFO entries; power of two, ≥2.
- `CNT_W`, 16 — width of the completed-operation counter.

- `clk`  in  1  — single clock; all state on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — upstream operands and divider outputs are valid.
- `in_ready`  out  1  — stage can accept this cycle.
- `in_a`  in  32  — dividend, IEEE-754 single.
- `in_b`  in  32  — divisor, IEEE-754 single.
- `in_result`  in  32  — raw divider result.
- `in_overflag`  in  1  — divider overflow flag.
- `in_underflag`  in  1  — divider underflow flag.
- `out_valid`  out  1  — FIFO head is valid.
- `out_ready`  in  1  — downstream accepts the head.
- `out_result`  out  32  — fixed-up result at the FIFO head.
- `out_flags`  out  4  — {invalid, divzero, overflow, underflow} for the head.
- `sticky_flags`  out  4  — OR of all flags pushed since reset or the last clear.
- `clear_sticky`  in  1  — synchronous clear of `sticky_flags`.
- `op_count`  out  CNT_W  — results popped; saturating.

## Operation
- Classification, combinational on the inputs:
  - exp==0xFF with frac≠0 is NaN.
  - exp==0xFF with frac==0 is inf.
  - exp==0 is zero. Denormals are flushed to zero; no flag is raised.
- Sign: `s = a[31]^b[31]`. Generated NaNs are always `0x7FC00000`.
- Fix-up priority, first match wins:
  1. A or B is NaN → `0x7FC00000`, invalid.
  2. A=0 and B=0, or A=inf and B=inf → `0x7FC00000`, invalid.
  3. A=inf → {s,0xFF,0}, no flag.
  4. B=0 → {s,0xFF,0}, divzero.
  5. B=inf or A=0 → {s,31'b0}, no flag.
  6. `in_overflag` → {s,0xFF,0}, overflow.
  7. `in_underflag` → {s,31'b0}, underflow.
  8. Otherwise → `in_result` unchanged, flags 0.
- Push: on `in_valid && in_ready`, the fixed-up {result, flags} is written at the FIFO tail.
- Pop: on `out_valid && out_ready`, the head is removed.
- FIFO: pointers wrap modulo DEPTH; occupancy counter runs 0..DEPTH.
- `in_ready = (count != DEPTH)`. It is registered-state based only. A pop in the same cycle does **not** free a slot for a push while full.
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both pointers advance.
- `out_valid = (count != 0)`. `out_result`/`out_flags` show the head entry; they read 0 when empty.
- Sticky flags: each cycle `sticky <= (clear_sticky ? 0 : sticky) | (push ? new_flags : 0)`. A flag pushed in the same cycle as `clear_sticky` survives the clear.
- `op_count`: increments on each pop and saturates at all-ones.

## Timing
- Reset (`rst_n` low, asynchronous): count=0, pointers=0, `out_valid`=0, `out_result`=0, `out_flags`=0, `sticky_flags`=0, `op_count`=0.
- While `rst_n` is low, `in_ready`=0. It goes to 1 on the first clock edge after release.
- Reset mid-operation discards all FIFO contents. No partial outputs are produced.
- Latency: input accepted at edge N → `out_valid`=1 with that result after edge N (visible in cycle N+1).
- Throughput: one result per cycle when `out_ready` is held high.
- Handshakes:
  - `in_*` must be held stable while `in_valid && !in_ready`.
  - The head and `out_valid` stay stable until popped.
  - Results leave in acceptance order.

## Test plan
- **Normal:** A=`0x40C00000`, B=`0x40000000`, in_result=`0x40400000`, flags 0 → `out_result`=`0x40400000`, `out_flags`=0, after 1 cycle.
- **Specials** (each followed by an expected `sticky_flags` check, then `clear_sticky`):
  - 1.0/0 (A=`0x3F800000`, B=0) → `0x7F800000`, divzero.
  - 0/0 → `0x7FC00000`, invalid.
  - A=`0xFF800000`, B=`0x3F800000` → `0xFF800000`, no flag.
  - A=`0x7FC00001` → `0x7FC00000`, invalid.
- **Saturation:** A=`0xC2000000`, B=`0x3F800000`, in_overflag=1 → `0xFF800000`, overflow. The same with in_underflag=1 → `0x80000000`, underflow.
- **Backpressure** (DEPTH=2): `out_ready`=0, offer 3 results → `in_ready` drops after 2 accepted and the 3rd is held. Then raise `out_ready` → outputs appear in order 1, 2, 3 and `op_count`=3.
- **Sticky collision:** `clear_sticky`=1 in the same cycle as pushing a divzero result → `sticky_flags`=`4'b0100` afterwards.
- **Reset mid-flight:** with 2 entries queued, pulse `rst_n` low asynchronously between edges → `out_valid`, `out_result`, `sticky_flags` and `op_count` drop to 0 immediately; `in_ready` returns to 1 on the first edge after release.
